// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial I2S pins plus the parallel sample outputs of the receiver.
// master = the serial source / sample consumer, slave = the receiver.
interface i2s_rx_if #(
    parameter int WIDTH = 16
);
    logic             bck;
    logic             ws;
    logic             din;
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic             sample_valid;
    logic             frame_err;

    modport master (
        output bck, ws, din,
        input  left_data, right_data, sample_valid, frame_err
    );

    modport slave (
        input  bck, ws, din,
        output left_data, right_data, sample_valid, frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receive slave. bck/ws/din are oversampled in the clk domain,
// words are deserialised MSB first and latched into left/right registers.
// Optional macro I2S_RX_FRAME_CHECK_EN enables short-word reporting on
// frame_err and drops the pending left word of a broken frame.
module i2s_rx #(
    parameter int WIDTH = 16,
    parameter int DELAY = 0
) (
    input  logic     clk,
    input  logic     rst,
    i2s_rx_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {HUNT, SKIP, SHIFT, IDLE} state_t;

    state_t           state_q, state_d;
    logic             bck_s1_q, bck_s2_q, bck_s3_q;
    logic             ws_s1_q, ws_s2_q;
    logic             din_s1_q, din_s2_q;
    logic             ws_prev_q, ws_seen_q;
    logic             word_ws_q, word_ws_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             bit_ev, start, shift_en, done;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic             ferr_q, ferr_d;
    logic             short_w;
`endif

    // two-flop synchronizers, third bck flop for rise detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck_s1_q <= 1'b0;
            bck_s2_q <= 1'b0;
            bck_s3_q <= 1'b0;
            ws_s1_q  <= 1'b0;
            ws_s2_q  <= 1'b0;
            din_s1_q <= 1'b0;
            din_s2_q <= 1'b0;
        end else begin
            bck_s1_q <= bus.bck;
            bck_s2_q <= bck_s1_q;
            bck_s3_q <= bck_s2_q;
            ws_s1_q  <= bus.ws;
            ws_s2_q  <= ws_s1_q;
            din_s1_q <= bus.din;
            din_s2_q <= din_s1_q;
        end
    end

    assign bit_ev = bck_s2_q & ~bck_s3_q;
    // the first bit event after reset only records ws, it cannot start a word
    assign start  = bit_ev & ws_seen_q & (ws_s2_q != ws_prev_q);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (done)
            state_d = IDLE;
        else if (start)
            state_d = (DELAY == 0) ? SHIFT : SKIP;
        else if (bit_ev && state_q == SKIP)
            state_d = SHIFT;
    end

    // control decode and datapath next values
    // SKIP is entered on the transition bit itself, so the next bit is the MSB
    always_comb begin
        word_ws_d = word_ws_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        left_d    = left_q;
        right_d   = right_q;
        pend_d    = pend_q;
        valid_d   = 1'b0;
        done      = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
        ferr_d    = 1'b0;
        short_w   = start && (state_q == SKIP || state_q == SHIFT);
`endif
        if (start) begin
            word_ws_d = ws_s2_q;
            cnt_d     = '0;
        end
        cnt_base = start ? '0 : cnt_q;
        shift_en = bit_ev && ((start && DELAY == 0) ||
                              (!start && (state_q == SHIFT || state_q == SKIP)));
        if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], din_s2_q};
            if (cnt_base != CNT_MAX)
                cnt_d = cnt_base + 1'b1;
            done = (cnt_base == CNT_LAST);
        end
`ifdef I2S_RX_FRAME_CHECK_EN
        if (short_w) begin
            ferr_d = 1'b1;
            pend_d = 1'b0;
        end
`endif
        if (done) begin
            if (word_ws_d) begin
                left_d = shreg_d;
                pend_d = 1'b1;
            end else begin
                right_d = shreg_d;
                valid_d = pend_q;
                pend_d  = 1'b0;
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_prev_q <= 1'b0;
            ws_seen_q <= 1'b0;
            word_ws_q <= 1'b0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (bit_ev) begin
                ws_prev_q <= ws_s2_q;
                ws_seen_q <= 1'b1;
            end
            word_ws_q <= word_ws_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            left_q    <= left_d;
            right_q   <= right_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    // short-word strobe register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ferr_q <= 1'b0;
        else     ferr_q <= ferr_d;
    end
    assign bus.frame_err = ferr_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.left_data    = left_q;
    assign bus.right_data   = right_q;
    assign bus.sample_valid = valid_q;
endmodule
